led_fade_driver: RTL and testbench

Output-side counterpart of the button/light path: consumes the synchronous on/off `light` level produced by the button on/off logic and drives the physical LED pin. The LED is not switched abruptly. A PWM generator ramps the duty cycle up when the level goes high and down when it goes low, with glitch-free updates aligned to PWM period boundaries. It sits between the on/off logic and the board LED pin, in the same clock domain.

---
 rtl/led_fade_driver.sv | 124 ++++++++++++
 tb/tb_led_fade_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - PWM LED driver that fades the duty cycle up and down
// following the registered on/off request.
module led_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                light_in,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);

    typedef enum logic [1:0] {
        S_OFF,
        S_UP,
        S_ON,
        S_DOWN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  light_q;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   duty_nxt;
    logic [PRE_W-1:0]      pre;
    logic [PRE_W-1:0]      pre_nxt;
    logic                  wrap;
    logic                  tick;
    logic                  enter_fade;

    assign wrap = (pwm_cnt == DUTY_MAX);
    assign tick = wrap && (pre == PRE_LAST);
    assign busy = (state == S_UP) || (state == S_DOWN);

    // A direction change always wins over a step landing in the same cycle.
    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty;
        enter_fade = 1'b0;
        case (state)
            S_OFF: begin
                duty_nxt = '0;
                if (light_q) begin
                    state_nxt  = S_UP;
                    enter_fade = 1'b1;
                end
            end
            S_UP: begin
                if (!light_q) begin
                    state_nxt  = S_DOWN;
                    enter_fade = 1'b1;
                end else if (tick) begin
                    if (duty >= DUTY_MAX - DUTY_ONE) begin
                        duty_nxt  = DUTY_MAX;
                        state_nxt = S_ON;
                    end else begin
                        duty_nxt = duty + DUTY_ONE;
                    end
                end
            end
            S_ON: begin
                duty_nxt = DUTY_MAX;
                if (!light_q) begin
                    state_nxt  = S_DOWN;
                    enter_fade = 1'b1;
                end
            end
            S_DOWN: begin
                if (light_q) begin
                    state_nxt  = S_UP;
                    enter_fade = 1'b1;
                end else if (tick) begin
                    if (duty <= DUTY_ONE) begin
                        duty_nxt  = '0;
                        state_nxt = S_OFF;
                    end else begin
                        duty_nxt = duty - DUTY_ONE;
                    end
                end
            end
            default: begin
                state_nxt = S_OFF;
                duty_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pre_nxt = pre;
        if (enter_fade) begin
            pre_nxt = '0;
        end else if (wrap) begin
            pre_nxt = tick ? '0 : pre + PRE_ONE;
        end
    end

    // Full-scale duty forces the pin solidly on instead of dropping one clock per period.
    always_ff @(posedge clk) begin
        if (reset) begin
            light_q <= 1'b0;
            pwm_cnt <= '0;
            pre     <= '0;
            state   <= S_OFF;
            duty    <= '0;
            led     <= 1'b0;
        end else begin
            light_q <= light_in;
            pwm_cnt <= pwm_cnt + DUTY_ONE;
            pre     <= pre_nxt;
            state   <= state_nxt;
            duty    <= duty_nxt;
            led     <= (duty == DUTY_MAX) || (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - randomized and directed bench for led_fade_driver
// against a time-based reference model.
module tb_led_fade_driver;

    localparam int PB   = 4;
    localparam int SD   = 2;
    localparam int PER  = 1 << PB;
    localparam int DMAX = PER - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          light_in = 1'b0;
    logic          led;
    logic [PB-1:0] duty;
    logic          busy;

    always #5 clk = ~clk;

    led_fade_driver #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .light_in (light_in),
        .led      (led),
        .duty     (duty),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: elapsed clocks give the PWM position, wraps since the last
    // direction change give the step schedule, and OFF/ON are implied by duty.
    int m_t, m_duty, m_dir, m_wraps, m_pos;
    bit m_lq, m_led;

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0; m_duty = 0; m_dir = 0; m_wraps = 0; m_lq = 0; m_led = 0;
        end else begin
            m_pos = m_t % PER;
            m_led = (m_duty == DMAX) || (m_pos < m_duty);
            if (m_dir == 0) begin
                if (m_lq && m_duty == 0) begin
                    m_dir = 1; m_wraps = 0;
                end else if (!m_lq && m_duty == DMAX) begin
                    m_dir = -1; m_wraps = 0;
                end
            end else if ((m_dir > 0) != m_lq) begin
                m_dir = -m_dir; m_wraps = 0;
            end else if (m_pos == PER - 1) begin
                m_wraps++;
                if (m_wraps % SD == 0) begin
                    m_duty += m_dir;
                    if (m_duty >= DMAX) begin
                        m_duty = DMAX; m_dir = 0;
                    end else if (m_duty <= 0) begin
                        m_duty = 0; m_dir = 0;
                    end
                end
            end
            m_lq = light_in;
            m_t++;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("model_duty", int'(duty), m_duty);
            check_eq("model_led", int'(led), int'(m_led));
            check_eq("model_busy", int'(busy), int'(m_dir != 0));
        end
    end

    task automatic watch_fade(input int dir, input int stop_at, input int budget);
        int prev, gap, steps;
        prev = int'(duty); gap = 0; steps = 0;
        for (int i = 0; i < budget && int'(duty) != stop_at; i++) begin
            @(negedge clk);
            gap++;
            if (int'(duty) != prev) begin
                check_eq("step_value", int'(duty), prev + dir);
                if (steps > 0) check_eq("step_gap", gap, SD * PER);
                steps++;
                gap  = 0;
                prev = int'(duty);
            end
        end
        check_eq("fade_reach", int'(duty), stop_at);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, maxd, hold;

        reset = 1'b1; light_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        repeat (8) @(negedge clk);
        check_eq("rst_duty", int'(duty), 0);
        check_eq("rst_led", int'(led), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("idle_duty", int'(duty), 0);
        check_eq("idle_busy", int'(busy), 0);

        light_in = 1'b1;
        @(negedge clk);
        check_eq("lat1_busy", int'(busy), 0);
        @(negedge clk);
        check_eq("lat2_busy", int'(busy), 1);
        watch_fade(1, DMAX, 700);
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(led);
        end
        check_eq("on_led_solid", cnt, 20);
        check_eq("on_busy", int'(busy), 0);

        light_in = 1'b0;
        watch_fade(-1, 5, 700);
        cnt = 0;
        repeat (PER) begin
            @(negedge clk);
            cnt += int'(led);
        end
        check_eq("pwm5_high", cnt, 5);
        watch_fade(-1, 0, 300);
        repeat (2) @(negedge clk);
        check_eq("off_busy", int'(busy), 0);
        check_eq("off_led", int'(led), 0);

        light_in = 1'b1;
        watch_fade(1, 6, 700);
        light_in = 1'b0;
        maxd = int'(duty);
        for (int i = 0; i < 100 && int'(duty) != 5; i++) begin
            @(negedge clk);
            if (int'(duty) > maxd) maxd = int'(duty);
        end
        check_eq("rev_max", maxd, 6);
        check_eq("rev_down", int'(duty), 5);
        light_in = 1'b1;
        watch_fade(1, 6, 100);
        light_in = 1'b0;
        watch_fade(-1, 0, 300);
        repeat (3) @(negedge clk);
        check_eq("rev_off_busy", int'(busy), 0);

        maxd = 0;
        for (int i = 0; i < 20; i++) begin
            light_in = ~light_in;
            repeat (10) begin
                @(negedge clk);
                if (int'(duty) > maxd) maxd = int'(duty);
            end
        end
        check_eq("toggle_max", maxd, 0);
        light_in = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("toggle_settle_busy", int'(busy), 0);

        light_in = 1'b1;
        watch_fade(1, 9, 700);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_duty", int'(duty), 0);
        check_eq("midrst_led", int'(led), 0);
        check_eq("midrst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rerun_lat1", int'(busy), 0);
        @(negedge clk);
        check_eq("rerun_lat2", int'(busy), 1);
        watch_fade(1, 3, 300);

        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end
            light_in = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 600) : $urandom_range(1, 60);
            repeat (hold) @(negedge clk);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
